instr_sequencer: RTL and testbench

- Fetch/issue controller that drives the lab CPU block from program memory.
- Each instruction cycle:
  - reads one 16-bit word from memory at the program counter;
  - loads it into the CPU instruction register via the load strobe;
  - pulses the CPU start input `s`;
  - waits for the CPU `w` handshake to report completion;
  - advances the PC.
- Sits between program memory and the CPU; owns PC, halt detection and a hang watchdog.

---
 rtl/instr_sequencer_if.sv | 24 ++
 rtl/instr_sequencer.sv | 132 +++++++++++++
 tb/tb_instr_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: program-memory read channel plus the CPU in/load/s/w handshake.
// master = sequencer side, slave = memory/CPU side.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       ir_out;
    logic              ir_load;
    logic              cpu_s;
    logic              cpu_w;

    modport master (
        output mem_rd, mem_addr, ir_out, ir_load, cpu_s,
        input  mem_ack, mem_rdata, cpu_w
    );

    modport slave (
        input  mem_rd, mem_addr, ir_out, ir_load, cpu_s,
        output mem_ack, mem_rdata, cpu_w
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: reads a word at pc, loads the CPU IR, pulses s, waits on w, advances pc.
// Latency FETCH(1+ack) + LOAD 1 + START 1 + WAIT_BUSY + WAIT_DONE; memory stalls hold mem_rd, CPU stalls hold the sequencer.
module instr_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] START_ADDR   = '0,
    parameter int                BUSY_TIMEOUT = 4,
    parameter logic [2:0]        HALT_OPCODE  = 3'b111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    instr_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [15:0]        instr_count
);

    localparam int             TW         = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD_IR,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HALTED
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            mem_rd_q;
    logic [15:0]     ir_q;
    logic            ir_load_q;
    logic            cpu_s_q;

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = pc;
    assign bus.ir_out   = ir_q;
    assign bus.ir_load  = ir_load_q;
    assign bus.cpu_s    = cpu_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            timer       <= '0;
            mem_rd_q    <= 1'b0;
            ir_q        <= 16'h0000;
            ir_load_q   <= 1'b0;
            cpu_s_q     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            // Strobes are single-cycle unless a transition below re-arms them.
            ir_load_q <= 1'b0;
            cpu_s_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        mem_rd_q <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        mem_rd_q <= 1'b0;
                        ir_q     <= bus.mem_rdata;
                        if (bus.mem_rdata[15:13] == HALT_OPCODE) begin
                            state  <= HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state     <= LOAD_IR;
                            ir_load_q <= 1'b1;
                        end
                    end
                end
                LOAD_IR: begin
                    state   <= START;
                    cpu_s_q <= 1'b1;
                end
                START: begin
                    state <= WAIT_BUSY;
                    timer <= '0;
                end
                WAIT_BUSY: begin
                    timer <= timer + 1'b1;
                    // A falling w wins over the watchdog on its last cycle.
                    if (!bus.cpu_w) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        state  <= HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.cpu_w) begin
                        pc <= pc + 1'b1;
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        if (run) begin
                            state    <= FETCH;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state    <= IDLE;
                    mem_rd_q <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench: reactive memory/CPU stimulus with a per-instruction timeline model
// derived from the phase latencies; one negedge process compares every output each cycle.
module tb_instr_sequencer;

    localparam int         ADDR_W = 8;
    localparam logic [7:0] START  = 8'hFF;
    localparam int         BT     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] instr_count;

    instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_sequencer #(
        .ADDR_W      (ADDR_W),
        .START_ADDR  (START),
        .BUSY_TIMEOUT(BT),
        .HALT_OPCODE (3'b111)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .bus         (bus.master),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem [256];

    // Architectural model state, updated at the edge it takes effect.
    logic [7:0]  m_pc;
    logic [15:0] m_cnt;
    logic [15:0] m_ir;
    logic        m_halted;
    logic        m_err;

    // Snapshot of the expected outputs for the current cycle.
    logic        e_rd, e_ld, e_s, e_busy, e_halted, e_err;
    logic [7:0]  e_pc;
    logic [15:0] e_cnt, e_ir;
    bit          chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
            if (e_rd) check("mem_addr", 32'(bus.mem_addr), 32'(e_pc));
            check("ir_load", 32'(bus.ir_load), 32'(e_ld));
            check("cpu_s", 32'(bus.cpu_s), 32'(e_s));
            check("busy", 32'(busy), 32'(e_busy));
            check("halted", 32'(halted), 32'(e_halted));
            check("err", 32'(err), 32'(e_err));
            check("pc", 32'(pc), 32'(e_pc));
            check("instr_count", 32'(instr_count), 32'(e_cnt));
            check("ir_out", 32'(bus.ir_out), 32'(e_ir));
        end
    end

    task automatic set_exp(input logic rd, input logic ld, input logic s, input logic bsy);
        e_rd     = rd;
        e_ld     = ld;
        e_s      = s;
        e_busy   = bsy;
        e_pc     = m_pc;
        e_cnt    = m_cnt;
        e_ir     = m_ir;
        e_halted = m_halted;
        e_err    = m_err;
    endtask

    task automatic cyc(input logic rd, input logic ld, input logic s, input logic bsy);
        @(posedge clk);
        #1;
        set_exp(rd, ld, s, bsy);
        chk_en = 1'b1;
    endtask

    // Inputs the sequencer must ignore in the current phase.
    task automatic noise();
        bus.mem_ack   = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = 16'($urandom);
        bus.cpu_w     = 1'($urandom);
        run           = 1'($urandom);
    endtask

    task automatic fill_mem(input bit allow_halt);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111 && !(allow_halt && $urandom_range(0, 3) == 0)) w[13] = 1'b0;
            mem[i] = w;
        end
    endtask

    task automatic halted_tail();
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            noise();
            if ($urandom_range(0, 1) == 1) bus.mem_rdata = 16'hE000;
        end
    endtask

    task automatic idle_until_run();
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            noise();
            run = (k == 11) || ($urandom_range(0, 2) == 0);
            if (run) break;
        end
    endtask

    // One instruction starting in its first FETCH cycle. exit_run<0 randomizes run at completion.
    task automatic do_instr(input int exit_run, input bit force_hang, output bit cont);
        int          lat, dec, ex;
        logic [15:0] word;
        lat  = $urandom_range(1, 3);
        dec  = force_hang ? BT + 2 : (($urandom_range(0, 1) == 0) ? 1 : $urandom_range(1, BT));
        ex   = $urandom_range(1, 4);
        word = mem[m_pc];
        cont = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            noise();
            bus.mem_ack   = (k == lat);
            bus.mem_rdata = (k == lat) ? word : 16'($urandom);
        end
        m_ir = word;
        if (word[15:13] == 3'b111) begin
            m_halted = 1'b1;
            halted_tail();
            return;
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        noise();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        noise();
        bus.cpu_w = 1'b1;
        // CPU holds w high for dec cycles after sampling s; watchdog allows BT cycles.
        for (int i = 0; i < BT; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            noise();
            bus.cpu_w = (i < dec);
            if (i >= dec) break;
        end
        if (dec >= BT) begin
            m_halted = 1'b1;
            m_err    = 1'b1;
            halted_tail();
            return;
        end
        for (int j = 1; j <= ex; j++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            noise();
            bus.cpu_w = (j == ex);
            if (j == ex && exit_run >= 0) run = 1'(exit_run);
        end
        cont  = run;
        m_pc  = m_pc + 8'd1;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, and offers a late halt-word ack.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset    = 1'b0;
        m_pc     = START;
        m_cnt    = 16'h0000;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
        m_err    = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_async_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_async_pc", 32'(pc), 32'(START));
        check("rst_async_busy", 32'(busy), 32'd0);
        run           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hE000;
        bus.cpu_w     = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
    endtask

    task automatic run_segment(input int max_instr);
        bit cont;
        idle_until_run();
        for (int n = 0; n < max_instr; n++) begin
            do_instr(-1, 1'b0, cont);
            if (m_halted) break;
            if (!cont && n < max_instr - 1) idle_until_run();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit cont;
        reset         = 1'b1;
        run           = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.cpu_w     = 1'b1;

        // Single MOV at the reset address, pc wraps FF -> 00, park, then resume.
        fill_mem(1'b0);
        mem[START] = 16'hD007;
        do_reset();
        idle_until_run();
        do_instr(0, 1'b0, cont);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        noise();
        run = 1'b0;
        check("t1_pc_wrap", 32'(pc), 32'h00);
        check("t1_count", 32'(instr_count), 32'd1);
        check("t1_ir", 32'(bus.ir_out), 32'hD007);
        check("t1_parked_rd", 32'(bus.mem_rd), 32'd0);
        idle_until_run();
        do_instr(-1, 1'b0, cont);

        // Normal instruction followed by a halt word.
        fill_mem(1'b0);
        mem[START] = 16'hA0A1;
        mem[8'h00] = 16'hE000;
        do_reset();
        idle_until_run();
        do_instr(1, 1'b0, cont);
        do_instr(-1, 1'b0, cont);
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_pc", 32'(pc), 32'h00);
        check("t2_count", 32'(instr_count), 32'd1);
        check("t2_ir", 32'(bus.ir_out), 32'hE000);

        // CPU never drops w: watchdog.
        fill_mem(1'b0);
        do_reset();
        idle_until_run();
        do_instr(-1, 1'b1, cont);
        check("t3_err", 32'(err), 32'd1);
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_pc", 32'(pc), 32'hFF);
        check("t3_count", 32'(instr_count), 32'd0);

        // Reset landing mid-fetch.
        fill_mem(1'b0);
        do_reset();
        idle_until_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        noise();
        bus.mem_ack = 1'b0;
        do_reset();

        for (int seg = 0; seg < 25; seg++) begin
            fill_mem(1'b1);
            do_reset();
            run_segment(30);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
